// File: rtl/slave_tt_core_oci_dct_ctrl_pkg.sv
// rtl/slave_tt_core_oci_dct_ctrl_pkg.sv - shared sizes and drain-state enum for the trace code packer
package slave_tt_core_oci_dct_ctrl_pkg;
    localparam int SLOTS  = 15;
    localparam int CODE_W = 2;
    localparam int BUF_W  = SLOTS * CODE_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_e;
endpackage

// File: rtl/slave_tt_core_oci_dct_hold.sv
// rtl/slave_tt_core_oci_dct_hold.sv - single-entry output holding register with valid/ready handshake
module slave_tt_core_oci_dct_hold
    import slave_tt_core_oci_dct_ctrl_pkg::*;
#(
    parameter int DATA_W = BUF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              out_ready,
    output logic              hold_free,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count
);
    assign hold_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/slave_tt_core_oci_dct_ctrl.sv
// rtl/slave_tt_core_oci_dct_ctrl.sv - packs trace codes into words, flushes on request and drains at end of test
module slave_tt_core_oci_dct_ctrl #(
    parameter int SLOTS  = slave_tt_core_oci_dct_ctrl_pkg::SLOTS,
    parameter int CODE_W = slave_tt_core_oci_dct_ctrl_pkg::CODE_W,
    localparam int BUF_W = SLOTS * CODE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] code,
    input  logic              flush_req,
    input  logic              test_ending,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BUF_W-1:0]  out_data,
    output logic [3:0]        out_count,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [3:0]        dct_count,
    output logic              overflow,
    output logic              test_has_ended
);
    import slave_tt_core_oci_dct_ctrl_pkg::*;

    localparam logic [3:0] SLOTS_C = 4'(SLOTS);

    dct_state_e       state, state_nxt;
    logic [BUF_W-1:0] buf_q;
    logic [3:0]       cnt_q;
    logic             flush_pend;
    logic             hold_free;
    logic             flush_eff;
    logic             xfer;
    logic             accept;

    always_comb begin
        // Once draining, every partial word is flushed as soon as the holding register frees
        flush_eff = flush_pend || (state != RUN);
        xfer      = hold_free && ((cnt_q == SLOTS_C) || (flush_eff && (cnt_q != 4'd0)));
        accept    = (state == RUN) && code_valid && ((cnt_q < SLOTS_C) || xfer);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (test_ending) state_nxt = DRAIN;
            DRAIN:   if ((cnt_q == 4'd0) && !out_valid) state_nxt = ENDED;
            ENDED:   state_nxt = ENDED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            buf_q      <= '0;
            cnt_q      <= 4'd0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                buf_q <= accept ? {{(BUF_W-CODE_W){1'b0}}, code} : '0;
                cnt_q <= accept ? 4'd1 : 4'd0;
            end else if (accept) begin
                buf_q <= {buf_q[BUF_W-CODE_W-1:0], code};
                cnt_q <= cnt_q + 4'd1;
            end
            flush_pend <= (flush_pend || flush_req) && !(xfer || (cnt_q == 4'd0));
            if ((state == RUN) && code_valid && !accept)
                overflow <= 1'b1;
        end
    end

    slave_tt_core_oci_dct_hold #(
        .DATA_W (BUF_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (xfer),
        .load_data  (buf_q),
        .load_count (cnt_q),
        .out_ready  (out_ready),
        .hold_free  (hold_free),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count)
    );

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_has_ended = (state == ENDED);
endmodule

// File: tb/tb_slave_tt_core_oci_dct_ctrl.sv
// tb/tb_slave_tt_core_oci_dct_ctrl.sv - directed vectors with hand-computed expectations for the trace code packer
module tb_slave_tt_core_oci_dct_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [1:0]  code;
    logic        flush_req;
    logic        test_ending;
    logic        out_ready;
    logic        out_valid;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_has_ended;

    int n_vec = 0;
    int n_bad = 0;
    int beats = 0;
    int beats_ref;

    always #5 clk = ~clk;

    slave_tt_core_oci_dct_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .code_valid     (code_valid),
        .code           (code),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    always @(posedge clk)
        if (!reset && out_valid && out_ready) beats <= beats + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; code_valid = 1'b0; code = 2'd0;
        flush_req = 1'b0; test_ending = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input int n, input logic [1:0] c);
        for (int i = 0; i < n; i++) begin
            code_valid = 1'b1; code = c;
            step();
        end
        code_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b1;
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_count", dct_count, 0);
        chk("rst_buf", dct_buffer, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ended", test_has_ended, 0);

        // full word of 2'b01
        send(15, 2'b01);
        chk("full_cnt", dct_count, 15);
        chk("full_nvalid", out_valid, 0);
        step();
        chk("full_valid", out_valid, 1);
        chk("full_data", out_data, 32'h15555555);
        chk("full_ocnt", out_count, 15);
        chk("full_clr", dct_count, 0);
        step();
        chk("full_once", out_valid, 0);
        chk("full_beats", beats, 1);
        chk("full_ovf", overflow, 0);

        // partial flush of 3,2,1
        send(1, 2'd3); send(1, 2'd2); send(1, 2'd1);
        flush_req = 1'b1; step(); flush_req = 1'b0;
        step();
        chk("fl_valid", out_valid, 1);
        chk("fl_data", out_data, 32'h39);
        chk("fl_ocnt", out_count, 3);
        step();
        beats_ref = beats;
        flush_req = 1'b1; step(); flush_req = 1'b0;
        step(); step();
        chk("fl_empty_valid", out_valid, 0);
        chk("fl_empty_beats", beats, beats_ref);

        // code arriving in the same cycle as the transfer
        send(15, 2'b01);
        send(1, 2'b10);
        chk("same_valid", out_valid, 1);
        chk("same_cnt", dct_count, 1);
        chk("same_buf", dct_buffer, 2);
        flush_req = 1'b1; step(); flush_req = 1'b0;
        step();
        chk("same_fl_data", out_data, 2);
        chk("same_fl_cnt", out_count, 1);
        step();

        // stalled downstream: overflow
        do_reset();
        out_ready = 1'b0;
        send(31, 2'b11);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_data", out_data, 32'h3FFFFFFF);
        chk("ovf_cnt", dct_count, 15);
        chk("ovf_flag", overflow, 1);
        step(); step();
        chk("ovf_sticky", overflow, 1);
        chk("ovf_hold", out_data, 32'h3FFFFFFF);
        out_ready = 1'b1;
        step();
        chk("ovf_reload_v", out_valid, 1);
        chk("ovf_reload_c", dct_count, 0);
        chk("ovf_reload_o", out_count, 15);
        step();
        chk("ovf_drained", out_valid, 0);
        chk("ovf_sticky2", overflow, 1);

        // reset mid-word with a held beat
        do_reset();
        out_ready = 1'b0;
        send(24, 2'b01);
        chk("mid_cnt", dct_count, 9);
        chk("mid_valid", out_valid, 1);
        beats_ref = beats;
        do_reset();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", dct_count, 0);
        chk("mid_rst_buf", dct_buffer, 0);
        chk("mid_rst_ocnt", out_count, 0);
        chk("mid_rst_data", out_data, 0);
        out_ready = 1'b1;
        step();
        chk("mid_rst_beats", beats, beats_ref);

        // end-of-test drain with 7 codes pending
        send(7, 2'b10);
        beats_ref = beats;
        test_ending = 1'b1; step(); test_ending = 1'b0;
        code_valid = 1'b1; code = 2'b11;
        step();
        chk("drn_valid", out_valid, 1);
        chk("drn_ocnt", out_count, 7);
        chk("drn_data", out_data, 32'h2AAA);
        chk("drn_not_ended", test_has_ended, 0);
        step();
        chk("drn_xfer", out_valid, 0);
        step();
        chk("drn_ended", test_has_ended, 1);
        for (int i = 0; i < 20; i++) step();
        code_valid = 1'b0;
        chk("drn_ign_cnt", dct_count, 0);
        chk("drn_ovf", overflow, 0);
        chk("drn_beats", beats, beats_ref + 1);
        chk("drn_still", test_has_ended, 1);

        // empty drain
        do_reset();
        test_ending = 1'b1; step(); test_ending = 1'b0;
        chk("empty_drain1", test_has_ended, 0);
        step();
        chk("empty_drain2", test_has_ended, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/slave_tt_core_oci_dct_ctrl.md
SLAVE_TT_CORE_OCI_DCT_CTRL -- requirements
Module: slave_tt_core_oci_dct_ctrl

Interface
REQ-001 Parameter SLOTS, default 15: trace codes per packed word.
REQ-002 Parameter CODE_W, default 2: width of one trace code; BUF_W = SLOTS*CODE_W = 30.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 code_valid  input  1  trace code present this cycle.
REQ-006 code  input  CODE_W  trace code.
REQ-007 flush_req  input  1  one-cycle request to emit a partially filled buffer.
REQ-008 test_ending  input  1  level or pulse; starts end-of-test drain.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_valid  output  1  holding register full.
REQ-011 out_data  output  BUF_W  packed word; valid codes in the low out_count*CODE_W bits.
REQ-012 out_count  output  4  number of valid codes in out_data, 1..SLOTS.
REQ-013 dct_buffer  output  BUF_W  live packing buffer.
REQ-014 dct_count  output  4  codes currently in dct_buffer, 0..SLOTS.
REQ-015 overflow  output  1  sticky; a code was dropped.
REQ-016 test_has_ended  output  1  sticky; drain complete.

Function
REQ-017 Accepted code shifts in at LSB: dct_buffer <= {dct_buffer[BUF_W-CODE_W-1:0], code}; dct_count increments; visible 1 cycle after acceptance.
REQ-018 hold_free = !out_valid || out_ready; a beat transfers downstream when out_valid && out_ready.
REQ-019 Transfer T = hold_free && (dct_count==SLOTS || (flush_pend && dct_count!=0)); on T, out_data/out_count load dct_buffer/dct_count, out_valid=1, dct_buffer clears to 0, dct_count clears to 0.
REQ-020 Full word reaches out_valid 2 cycles after the SLOTS-th code is accepted when hold_free.
REQ-021 Code accepted in RUN when dct_count<SLOTS or T; on simultaneous T and accept, the code becomes slot 0 of the cleared buffer (dct_count=1).
REQ-022 Code in RUN with dct_count==SLOTS and !T is dropped; overflow sets and holds until reset.
REQ-023 flush_req sets flush_pend; flush_pend clears on T or when dct_count==0; flush_req with an empty buffer produces no output.
REQ-024 out_valid clears on transfer unless T reloads in the same cycle; out_data stable while out_valid && !out_ready.
REQ-025 States: RUN, DRAIN, ENDED. RUN->DRAIN on test_ending; DRAIN->ENDED when dct_count==0 && !out_valid; ENDED terminal until reset.
REQ-026 In DRAIN and ENDED, flush_pend is forced to 1, code_valid is ignored, and overflow is not set.
REQ-027 test_has_ended=1 exactly in ENDED, first asserted the cycle after the last word is accepted downstream.
REQ-028 test_ending with an empty buffer and empty holding register reaches ENDED 2 cycles later (RUN->DRAIN->ENDED).

Reset
REQ-029 reset, synchronous, active-high: state=RUN; dct_buffer, dct_count, out_data, out_count, out_valid, flush_pend, overflow and test_has_ended all 0.
REQ-030 reset mid-word or mid-drain discards all buffered data without emitting it; reset has priority over every other input.

Structure
REQ-031 A shared package holds SLOTS, CODE_W, BUF_W and the 2-bit state enum {RUN, DRAIN, ENDED}.
REQ-032 The output holding register and its valid/ready logic are one sub-module, slave_tt_core_oci_dct_hold; packing, flush and the FSM stay in the top module.

Verification
REQ-033 15 codes 2'b01 back-to-back, out_ready=1 -> out_valid for 1 cycle with out_data=30'h15555555, out_count=15, overflow=0.
REQ-034 3 codes (3,2,1) then flush_req -> out_data=30'h39, out_count=3; a flush_req on the now-empty buffer produces no beat.
REQ-035 out_ready=0, 31 codes sent -> first word held, second buffer full (dct_count=15), 31st code dropped, overflow=1 and stays 1.
REQ-036 Code arriving in the same cycle as T -> dct_count=1 and dct_buffer holds that code after the edge.
REQ-037 7 codes then test_ending, out_ready=1 -> one beat with out_count=7, then test_has_ended=1; later codes ignored, overflow=0.
REQ-038 reset asserted with dct_count=9 and out_valid=1 -> next cycle all outputs 0, state RUN, no beat emitted.
